// File: rtl/vga_pkg.sv
// Shared VGA raster constants, total-size helpers and the sync/blank payload
// carried by the pixel delay line.
package vga_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned DIV_W     = 4;
  localparam int unsigned MAX_TOTAL = 1024;

  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_PIPE_DLY = 1;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } vid_ctl_t;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Shift register that advances only on pixel steps; DEPTH=0 is a plain wire.
module pix_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, reset, adv};
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
      stage_d = stage_q;
      if (adv) begin
        stage_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel strobe, x/y scan counters and sync/blank decode,
// with sync/blank delayed to match downstream pixel latency.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DLY = DEF_PIPE_DLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned CMP_W    = CNT_W + 1;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_ctrl: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16 || PIPE_DLY > 7) begin : g_bad_param
    $error("vga_timing_ctrl: CLK_DIV or PIPE_DLY out of range");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic [CMP_W-1:0] hpos, vpos;
  vid_ctl_t         ctl_now, ctl_dly;

  assign pix_en = en && (div_q == DIV_W'(CLK_DIV - 1));

  // Divider free-runs under en; counters step once per pixel strobe.
  always_comb begin
    div_d  = div_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (en) begin
      div_d = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    end
    if (pix_en) begin
      if (hcnt_q == CNT_W'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : vcnt_q + CNT_W'(1);
      end else begin
        hcnt_d = hcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Compare one bit wider so sync windows ending at the total stay exact.
  assign hpos = {1'b0, hcnt_q};
  assign vpos = {1'b0, vcnt_q};

  always_comb begin
    ctl_now     = '0;
    ctl_now.act = (hpos < CMP_W'(H_ACTIVE)) && (vpos < CMP_W'(V_ACTIVE));
    ctl_now.hs  = (hpos >= CMP_W'(HS_START)) && (hpos < CMP_W'(HS_END));
    ctl_now.vs  = (vpos >= CMP_W'(VS_START)) && (vpos < CMP_W'(VS_END));
  end

  pix_delay_line #(
    .DEPTH (PIPE_DLY),
    .WIDTH ($bits(vid_ctl_t))
  ) u_dly (
    .clk   (clk),
    .reset (reset),
    .adv   (pix_en),
    .din   (ctl_now),
    .dout  (ctl_dly)
  );

  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign blank_n     = ctl_dly.act;
  assign hsync       = ctl_dly.hs ? SYNC_POL : ~SYNC_POL;
  assign vsync       = ctl_dly.vs ? SYNC_POL : ~SYNC_POL;
  assign line_start  = pix_en && (hcnt_q == '0);
  assign frame_start = pix_en && (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl: three instances (default raster with
// PIPE_DLY 1 and 0, plus a small fast-wrapping raster) against a pixel-index model.
module tb_vga_timing_ctrl;

  typedef struct {
    int d, ha, hf, hs, hb, va, vf, vs, vb, n;
    bit pol;
  } tim_t;

  typedef struct {
    int cyc, x, y;
    bit blank_n, hsync, vsync, ls, fs;
  } exp_t;

  localparam tim_t TA = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0};
  localparam tim_t TB = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0};
  localparam tim_t TS = '{3, 20, 2, 4, 3, 12, 2, 2, 3, 2, 1'b1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;

  logic       pe_a, hs_a, vs_a, bn_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       pe_b, hs_b, vs_b, bn_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       pe_s, hs_s, vs_s, bn_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   e_cnt = 0;
  exp_t sbq [3][$];

  always #5 clk = ~clk;

  vga_timing_ctrl #(.PIPE_DLY(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .pix_en(pe_a), .x(x_a), .y(y_a),
    .hsync(hs_a), .vsync(vs_a), .blank_n(bn_a), .line_start(ls_a), .frame_start(fs_a));

  vga_timing_ctrl #(.PIPE_DLY(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .pix_en(pe_b), .x(x_b), .y(y_b),
    .hsync(hs_b), .vsync(vs_b), .blank_n(bn_b), .line_start(ls_b), .frame_start(fs_b));

  vga_timing_ctrl #(
    .CLK_DIV(3), .H_ACTIVE(20), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1), .PIPE_DLY(2)
  ) dut_s (
    .clk(clk), .reset(reset), .en(en), .pix_en(pe_s), .x(x_s), .y(y_s),
    .hsync(hs_s), .vsync(vs_s), .blank_n(bn_s), .line_start(ls_s), .frame_start(fs_s));

  // Outputs seen while pixel c is current: position of c, sync/blank of pixel c-n.
  function automatic exp_t expect_at(input tim_t t, input int c, input int cyc_i);
    int ht, vt, p, px, py;
    exp_t r;
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    r.cyc     = cyc_i;
    r.x       = c % ht;
    r.y       = (c / ht) % vt;
    r.ls      = (r.x == 0);
    r.fs      = (r.x == 0) && (r.y == 0);
    r.blank_n = 1'b0;
    r.hsync   = ~t.pol;
    r.vsync   = ~t.pol;
    if (c >= t.n) begin
      p  = c - t.n;
      px = p % ht;
      py = (p / ht) % vt;
      r.blank_n = (px < t.ha) && (py < t.va);
      if (px >= t.ha + t.hf && px < t.ha + t.hf + t.hs) r.hsync = t.pol;
      if (py >= t.va + t.vf && py < t.va + t.vf + t.vs) r.vsync = t.pol;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, req);
    end
  endtask

  // One negedge-to-negedge cycle of stimulus; expected pixels go to the scoreboard.
  task automatic step(input bit r, input bit en_i);
    @(negedge clk);
    reset = r;
    en    = r ? 1'b0 : en_i;
    cyc++;
    if (!r && en_i) begin
      if (e_cnt % TA.d == TA.d - 1) begin
        sbq[0].push_back(expect_at(TA, e_cnt / TA.d, cyc));
        sbq[1].push_back(expect_at(TB, e_cnt / TB.d, cyc));
      end
      if (e_cnt % TS.d == TS.d - 1) sbq[2].push_back(expect_at(TS, e_cnt / TS.d, cyc));
    end
    e_cnt = r ? 0 : e_cnt + (en_i ? 1 : 0);
  endtask

  task automatic mon(input int id, input string nm, input logic pe, input int ax, input int ay,
                     input logic bn, input logic hsy, input logic vsy, input logic ls, input logic fs);
    exp_t ex;
    bit   exp_pe;
    exp_pe = (sbq[id].size() != 0) && (sbq[id][0].cyc == cyc);
    chk({nm, "_pix_en"}, int'(pe), int'(exp_pe));
    if (exp_pe) begin
      ex = sbq[id].pop_front();
      if (pe) begin
        chk({nm, "_x"}, ax, ex.x);
        chk({nm, "_y"}, ay, ex.y);
        chk({nm, "_blank_n"}, int'(bn), int'(ex.blank_n));
        chk({nm, "_hsync"}, int'(hsy), int'(ex.hsync));
        chk({nm, "_vsync"}, int'(vsy), int'(ex.vsync));
        chk({nm, "_line_start"}, int'(ls), int'(ex.ls));
        chk({nm, "_frame_start"}, int'(fs), int'(ex.fs));
      end
    end else if (!pe) begin
      chk({nm, "_line_start_idle"}, int'(ls), 0);
      chk({nm, "_frame_start_idle"}, int'(fs), 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      mon(0, "a", pe_a, int'(x_a), int'(y_a), bn_a, hs_a, vs_a, ls_a, fs_a);
      mon(1, "b", pe_b, int'(x_b), int'(y_b), bn_b, hs_b, vs_b, ls_b, fs_b);
      mon(2, "s", pe_s, int'(x_s), int'(y_s), bn_s, hs_s, vs_s, ls_s, fs_s);
    end
  end

  task automatic check_reset_state();
    chk("rst_x", int'(x_a), 0);
    chk("rst_y", int'(y_a), 0);
    chk("rst_pix_en", int'(pe_a), 0);
    chk("rst_blank_n_dly1", int'(bn_a), 0);
    chk("rst_blank_n_dly0", int'(bn_b), 1);
    chk("rst_hsync", int'(hs_a), 1);
    chk("rst_vsync", int'(vs_a), 1);
    chk("rst_s_blank_n", int'(bn_s), 0);
    chk("rst_s_hsync", int'(hs_s), 0);
    chk("rst_s_vsync", int'(vs_s), 0);
  endtask

  task automatic hold_window();
    exp_t ex;
    ex = expect_at(TA, e_cnt / TA.d, 0);
    repeat (10) begin
      step(1'b0, 1'b0);
      #1;
      chk("hold_x", int'(x_a), 300);
      chk("hold_pix_en", int'(pe_a), 0);
      chk("hold_hsync", int'(hs_a), int'(ex.hsync));
      chk("hold_blank_n", int'(bn_a), int'(ex.blank_n));
    end
  endtask

  initial begin
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    #1;
    check_reset_state();

    // Free run over the first lines, pausing once at x=300.
    for (int i = 0; i < 3400; i++) begin
      if (e_cnt == 601) hold_window();
      step(1'b0, 1'b1);
    end

    for (int i = 0; i < 6000; i++) step(1'b0, $urandom_range(0, 3) != 0);

    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    #1;
    check_reset_state();

    for (int i = 0; i < 600; i++) step(1'b0, $urandom_range(0, 3) != 0);
    repeat (3) step(1'b0, 1'b0);
    #2;
    chk("a_queue_drained", sbq[0].size(), 0);
    chk("b_queue_drained", sbq[1].size(), 0);
    chk("s_queue_drained", sbq[2].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
